// File: rtl/perm8_note_sequencer.sv
// Purpose : plays a snapshot of the 8-element permutation as eight MIDI notes, then pulses nxt.
// Latency : LOAD->first byte offered 1 cycle; step = 3 bytes + TICKS_PER_STEP + 3 bytes, back to back.
// Backpr. : byte_valid/byte_out held until byte_ready; no byte dropped, duplicated or withdrawn.
//
// Ports:
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   enable            level; 1 runs the sequence, 0 stops once the current step has finished
//   op0..op7          permutation elements from the engine, sampled only in LOAD
//   nxt               one-cycle pulse asking the engine for the next permutation
//   byte_out/_valid   MIDI byte stream toward the sink; byte_ready accepts it
//   step_idx          position (0-7) currently playing
//   busy              high in every state except IDLE
module perm8_note_sequencer #(
  parameter int unsigned TICKS_PER_STEP = 6000,
  parameter logic [6:0]  BASE_NOTE      = 7'd60,
  parameter logic [6:0]  VELOCITY       = 7'd100,
  parameter logic [3:0]  CHANNEL        = 4'd0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       enable,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [2:0] op2,
  input  logic [2:0] op3,
  input  logic [2:0] op4,
  input  logic [2:0] op5,
  input  logic [2:0] op6,
  input  logic [2:0] op7,
  output logic       nxt,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic [2:0] step_idx,
  output logic       busy
);

  // Tick counter runs 0..TICKS_PER_STEP-1 inside WAIT.
  localparam int TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_STEP - 1);

  localparam logic [7:0] STATUS_ON  = {4'h9, CHANNEL};
  localparam logic [7:0] STATUS_OFF = {4'h8, CHANNEL};

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LOAD    = 4'd1;
  localparam logic [3:0] S_ON0     = 4'd2;
  localparam logic [3:0] S_ON1     = 4'd3;
  localparam logic [3:0] S_ON2     = 4'd4;
  localparam logic [3:0] S_WAIT    = 4'd5;
  localparam logic [3:0] S_OFF0    = 4'd6;
  localparam logic [3:0] S_OFF1    = 4'd7;
  localparam logic [3:0] S_OFF2    = 4'd8;
  localparam logic [3:0] S_ADVANCE = 4'd9;

  logic [3:0]      state, state_d;
  logic [7:0][2:0] snap, snap_d;
  logic [TW-1:0]   tick, tick_d;
  logic [2:0]      step_d;
  logic [7:0]      byte_out_d;
  logic            byte_valid_d;
  logic            nxt_d;
  logic            xfer;
  logic [7:0]      cur_note;

  // Major-scale offset above BASE_NOTE, clamped to the 7-bit MIDI range.
  function automatic logic [7:0] note_of(input logic [2:0] v);
    logic [3:0] off;
    logic [7:0] sum;
    case (v)
      3'd0:    off = 4'd0;
      3'd1:    off = 4'd2;
      3'd2:    off = 4'd4;
      3'd3:    off = 4'd5;
      3'd4:    off = 4'd7;
      3'd5:    off = 4'd9;
      3'd6:    off = 4'd11;
      default: off = 4'd12;
    endcase
    sum = {1'b0, BASE_NOTE} + {4'd0, off};
    note_of = (sum > 8'd127) ? 8'd127 : sum;
  endfunction

  assign xfer     = byte_valid & byte_ready;
  assign cur_note = note_of(snap[step_idx]);
  assign busy     = (state != S_IDLE);

  // Output registers are loaded with the value belonging to the state being
  // entered, so byte_out/byte_valid are glitch-free and stable under stall.
  always_comb begin
    state_d      = state;
    snap_d       = snap;
    tick_d       = tick;
    step_d       = step_idx;
    byte_out_d   = byte_out;
    byte_valid_d = byte_valid;
    nxt_d        = 1'b0;
    case (state)
      S_IDLE: begin
        // No nxt here: the permutation already held by the engine plays first.
        if (enable) state_d = S_LOAD;
      end
      S_LOAD: begin
        snap_d       = {op7, op6, op5, op4, op3, op2, op1, op0};
        step_d       = 3'd0;
        state_d      = S_ON0;
        byte_valid_d = 1'b1;
        byte_out_d   = STATUS_ON;
      end
      S_ON0: begin
        if (xfer) begin
          state_d    = S_ON1;
          byte_out_d = cur_note;
        end
      end
      S_ON1: begin
        if (xfer) begin
          state_d    = S_ON2;
          byte_out_d = {1'b0, VELOCITY};
        end
      end
      S_ON2: begin
        if (xfer) begin
          state_d      = S_WAIT;
          byte_valid_d = 1'b0;
          tick_d       = '0;
        end
      end
      S_WAIT: begin
        if (tick == TICK_LAST) begin
          state_d      = S_OFF0;
          byte_valid_d = 1'b1;
          byte_out_d   = STATUS_OFF;
        end else begin
          tick_d = tick + TW'(1);
        end
      end
      S_OFF0: begin
        if (xfer) begin
          state_d    = S_OFF1;
          byte_out_d = cur_note;
        end
      end
      S_OFF1: begin
        if (xfer) begin
          state_d    = S_OFF2;
          byte_out_d = 8'h00;
        end
      end
      S_OFF2: begin
        // enable is only consulted here, so a note is never left hanging.
        if (xfer) begin
          if (!enable) begin
            state_d      = S_IDLE;
            byte_valid_d = 1'b0;
          end else if (step_idx != 3'd7) begin
            state_d      = S_ON0;
            step_d       = step_idx + 3'd1;
            byte_valid_d = 1'b1;
            byte_out_d   = STATUS_ON;
          end else begin
            state_d      = S_ADVANCE;
            byte_valid_d = 1'b0;
            nxt_d        = 1'b1;
          end
        end
      end
      S_ADVANCE: begin
        // Engine steps on this cycle's closing edge; LOAD samples it one edge later.
        state_d = S_LOAD;
      end
      default: begin
        state_d      = S_IDLE;
        byte_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      snap       <= '0;
      tick       <= '0;
      step_idx   <= 3'd0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      nxt        <= 1'b0;
    end else begin
      state      <= state_d;
      snap       <= snap_d;
      tick       <= tick_d;
      step_idx   <= step_d;
      byte_out   <= byte_out_d;
      byte_valid <= byte_valid_d;
      nxt        <= nxt_d;
    end
  end

endmodule

// File: tb/tb_perm8_note_sequencer.sv
module tb_perm8_note_sequencer;

  localparam int TK     = 4;
  localparam int BUDGET = 3000;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            enable;
  logic            byte_ready;
  logic [7:0][2:0] ops;
  logic            nxt;
  logic [7:0]      byte_out;
  logic            byte_valid;
  logic [2:0]      step_idx;
  logic            busy;

  logic            s_enable;
  logic            s_byte_ready;
  logic [7:0][2:0] s_ops;
  logic            s_nxt;
  logic [7:0]      s_byte_out;
  logic            s_byte_valid;
  logic [2:0]      s_step_idx;
  logic            s_busy;

  int total = 0;
  int bad = 0;
  int nxt_count = 0;
  int s_nxt_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sq[$];

  logic       bp_mode = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int         bp_ph = 0;

  always #5 CLK = ~CLK;

  perm8_note_sequencer #(.TICKS_PER_STEP(TK), .BASE_NOTE(7'd60), .VELOCITY(7'd100), .CHANNEL(4'd0)) dut (
    .CLK(CLK), .RST_N(RST_N), .enable(enable),
    .op0(ops[0]), .op1(ops[1]), .op2(ops[2]), .op3(ops[3]),
    .op4(ops[4]), .op5(ops[5]), .op6(ops[6]), .op7(ops[7]),
    .nxt(nxt), .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .step_idx(step_idx), .busy(busy)
  );

  perm8_note_sequencer #(.TICKS_PER_STEP(1), .BASE_NOTE(7'd120), .VELOCITY(7'd33), .CHANNEL(4'd5)) dut_sat (
    .CLK(CLK), .RST_N(RST_N), .enable(s_enable),
    .op0(s_ops[0]), .op1(s_ops[1]), .op2(s_ops[2]), .op3(s_ops[3]),
    .op4(s_ops[4]), .op5(s_ops[5]), .op6(s_ops[6]), .op7(s_ops[7]),
    .nxt(s_nxt), .byte_out(s_byte_out), .byte_valid(s_byte_valid), .byte_ready(s_byte_ready),
    .step_idx(s_step_idx), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] note_ref(input int base, input logic [2:0] v);
    int off;
    int n;
    case (v)
      3'd0: off = 0;
      3'd1: off = 2;
      3'd2: off = 4;
      3'd3: off = 5;
      3'd4: off = 7;
      3'd5: off = 9;
      3'd6: off = 11;
      default: off = 12;
    endcase
    n = base + off;
    return (n > 127) ? 8'd127 : 8'(n);
  endfunction

  // Engine model: next permutation in lexicographic order, position 0 most significant.
  function automatic logic [7:0][2:0] next_perm(input logic [7:0][2:0] p);
    logic [7:0][2:0] r;
    logic [2:0] t;
    int i;
    int j;
    int lo;
    int hi;
    r = p;
    i = 6;
    while (i >= 0 && r[i] >= r[i+1]) i--;
    if (i >= 0) begin
      j = 7;
      while (r[j] <= r[i]) j--;
      t = r[i]; r[i] = r[j]; r[j] = t;
    end
    lo = i + 1;
    hi = 7;
    while (lo < hi) begin
      t = r[lo]; r[lo] = r[hi]; r[hi] = t;
      lo++; hi--;
    end
    return r;
  endfunction

  task automatic push_main(input logic [2:0] v);
    exp_q.push_back(8'h90);
    exp_q.push_back(note_ref(60, v));
    exp_q.push_back(8'd100);
    exp_q.push_back(8'h80);
    exp_q.push_back(note_ref(60, v));
    exp_q.push_back(8'h00);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (bp_mode) begin
      byte_ready = bp_pat[bp_ph];
      bp_ph = (bp_ph + 1) % 4;
    end
  endtask

  // Scoreboard / protocol monitor, sampled mid-cycle.
  int         cyc = 0;
  int         last_xfer = 0;
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pb = 8'h00;

  always @(negedge CLK) begin
    cyc++;
    if (!RST_N) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", byte_valid, 1);
        chk("hold_byte", byte_out, pb);
      end
      if (!pv && byte_valid && byte_out == 8'h80)
        chk("wait_gap", cyc - last_xfer, TK + 1);
      if (byte_valid && byte_ready) begin
        chk("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("byte_val", byte_out, exp_q.pop_front());
        last_xfer = cyc;
      end
      if (nxt) begin
        nxt_count++;
        chk("nxt_all_played", exp_q.size(), 0);
        chk("nxt_step7", step_idx, 7);
      end
      if (s_byte_valid && s_byte_ready) begin
        chk("sat_byte_expected", sq.size() != 0, 1);
        if (sq.size() != 0) chk("sat_byte_val", s_byte_out, sq.pop_front());
      end
      if (s_nxt) s_nxt_count++;
      pv = byte_valid;
      pr = byte_ready;
      pb = byte_out;
    end
  end

  initial begin
    int n;
    RST_N = 1'b0;
    enable = 1'b0;
    byte_ready = 1'b0;
    s_enable = 1'b0;
    s_byte_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ops[k] = 3'(k);
      s_ops[k] = 3'(7 - k);
    end
    repeat (3) tick();
    chk("rst_valid", byte_valid, 0);
    chk("rst_nxt", nxt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step", step_idx, 0);
    chk("rst_byte", byte_out, 8'h00);

    RST_N = 1'b1;
    repeat (5) tick();
    chk("idle_busy", busy, 0);
    chk("idle_valid", byte_valid, 0);

    // Identity permutation, full sequence.
    byte_ready = 1'b1;
    for (int k = 0; k < 8; k++) push_main(ops[k]);
    enable = 1'b1;

    n = 0;
    while (!(step_idx == 3'd1 && busy && !byte_valid) && n < BUDGET) begin tick(); n++; end
    chk("reach_step1_wait", n < BUDGET, 1);
    enable = 1'b0;
    tick();
    enable = 1'b1;

    n = 0;
    while (step_idx != 3'd2 && n < BUDGET) begin tick(); n++; end
    chk("reach_step2", n < BUDGET, 1);
    for (int k = 0; k < 8; k++) ops[k] = 3'd7;
    bp_mode = 1'b1;

    n = 0;
    while (step_idx != 3'd5 && n < BUDGET) begin tick(); n++; end
    chk("reach_step5", n < BUDGET, 1);
    bp_mode = 1'b0;
    byte_ready = 1'b1;
    for (int k = 0; k < 8; k++) ops[k] = 3'(k);

    n = 0;
    while (!nxt && n < BUDGET) begin tick(); n++; end
    chk("nxt_seen", n < BUDGET, 1);
    ops = next_perm(ops);
    tick();
    chk("nxt_one_cycle", nxt, 0);
    for (int k = 0; k < 4; k++) push_main(ops[k]);

    // Stop during WAIT of step 3 of the second permutation.
    n = 0;
    while (!(step_idx == 3'd3 && busy && !byte_valid) && n < BUDGET) begin tick(); n++; end
    chk("reach_step3_wait", n < BUDGET, 1);
    enable = 1'b0;
    n = 0;
    while (busy && n < BUDGET) begin tick(); n++; end
    chk("stop_idle", n < BUDGET, 1);
    chk("stop_step_idx", step_idx, 3);
    chk("stop_q_empty", exp_q.size(), 0);
    chk("stop_nxt_count", nxt_count, 1);
    repeat (20) tick();
    chk("stop_still_idle", busy, 0);

    // Asynchronous reset in the middle of WAIT.
    exp_q.push_back(8'h90);
    exp_q.push_back(note_ref(60, ops[0]));
    exp_q.push_back(8'd100);
    enable = 1'b1;
    n = 0;
    while (!(step_idx == 3'd0 && busy && !byte_valid) && n < BUDGET) begin tick(); n++; end
    chk("reach_rst_wait", n < BUDGET, 1);
    enable = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("arst_valid", byte_valid, 0);
    chk("arst_nxt", nxt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_step", step_idx, 0);
    tick();
    RST_N = 1'b1;
    repeat (15) tick();
    chk("arst_q_empty", exp_q.size(), 0);
    chk("arst_idle", busy, 0);

    // Saturation: position 0 holds 7, BASE_NOTE=120 -> 127.
    sq.push_back({4'h9, 4'd5});
    sq.push_back(note_ref(120, s_ops[0]));
    sq.push_back(8'd33);
    sq.push_back({4'h8, 4'd5});
    sq.push_back(note_ref(120, s_ops[0]));
    sq.push_back(8'h00);
    s_enable = 1'b1;
    n = 0;
    while (!s_busy && n < BUDGET) begin tick(); n++; end
    chk("sat_start", n < BUDGET, 1);
    s_enable = 1'b0;
    n = 0;
    while (s_busy && n < BUDGET) begin tick(); n++; end
    chk("sat_done", n < BUDGET, 1);
    chk("sat_q_empty", sq.size(), 0);
    chk("sat_step", s_step_idx, 0);
    chk("sat_nxt_count", s_nxt_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
